data_mem_mmio: RTL
==================

DATA_MEM_MMIO -- requirements
Module: data_mem_mmio

Interface
REQ-001 Parameters SHALL be, one per line:
- DATA_W, 32, data width; multiple of 8, at least 32.
- ADDR_W, 10, byte-address width.
- IO_BASE, 64, byte address of the MMIO window; word-aligned.
- N_IN, 2, number of read-only input ports.
- N_OUT, 2, number of read/write output ports.
- LATENCY, 1, accept-to-response cycles; range 1..4.

REQ-002 Ports SHALL be, one per line (name, direction, width, meaning):
- clock, in, 1, sole clock, rising edge.
- reset, in, 1, asynchronous, active-low reset.
- ReqValid, in, 1, request present.
- ReqReady, out, 1, block can accept a request.
- ReqWrite, in, 1, 1 = store, 0 = load.
- ReqSize, in, 2, 0 = byte, 1 = half, 2 = word; 3 is illegal.
- ReqUnsigned, in, 1, zero-extend loads.
- ReqAddr, in, ADDR_W, byte address.
- ReqData, in, DATA_W, store data, right-justified.
- RspValid, out, 1, one-cycle response strobe.
- RspData, out, DATA_W, load result.
- RspError, out, 1, request faulted.
- InpWord, in, N_IN x DATA_W, external input words.
- OutWord, out, N_OUT x DATA_W, registered output words.

Function
REQ-003 Address map SHALL be:
- RAM: bytes 0..IO_BASE-1, little-endian.
- InpWord[i]: IO_BASE+4i.
- OutWord[j]: IO_BASE+4(N_IN+j).
- Any other address is unmapped.

REQ-004 FSM SHALL have states IDLE, WAIT and RESP; ReqReady=1 only in IDLE.

REQ-005 A request SHALL be accepted on a rising edge where ReqValid=1 and ReqReady=1.
- Next state is RESP if LATENCY=1, else WAIT.

REQ-006 WAIT SHALL count LATENCY-1 cycles, then go to RESP.

REQ-007 RESP SHALL hold RspValid=1 for exactly one cycle, then return to IDLE.
- There is no response back-pressure.
- Maximum throughput is one request per LATENCY+1 cycles.

REQ-008 Timing of stores and load sampling:
- Stores SHALL update storage on the accept edge.
- Loads SHALL sample storage and InpWord on the accept edge.
- RspData, RspError and the captured state SHALL hold stable from accept until RspValid falls.

REQ-009 Store byte lanes:
- Byte stores SHALL write lane ReqAddr[1:0].
- Half stores SHALL write lanes {ReqAddr[1],0} and {ReqAddr[1],1}.
- Other lanes are unchanged.

REQ-010 Load extension:
- Byte and half loads SHALL sign-extend when ReqUnsigned=0 and zero-extend when ReqUnsigned=1.
- Word loads ignore ReqUnsigned.

REQ-011 RspError=1 SHALL flag any of:
- misaligned half (ReqAddr[0]=1);
- misaligned word (ReqAddr[1:0]!=0);
- ReqSize=3;
- unmapped address;
- store to an InpWord address.

On error: no state change, RspData=0.

REQ-012 Sub-word accesses to MMIO words SHALL obey REQ-009 and REQ-010 exactly as RAM accesses do.

REQ-013 Store responses SHALL assert RspValid with RspData=0.

REQ-014 ReqValid is ignored outside IDLE; a held ReqValid is accepted again on the first IDLE edge.

REQ-015 OutWord[j] SHALL be driven directly from its register: visible the cycle after the accept edge, no further delay.

Reset
REQ-016 reset=0 SHALL asynchronously set the following, regardless of any in-flight request, which is discarded:
- FSM to IDLE;
- counter to 0;
- RspValid, RspData and RspError to 0;
- every OutWord to 0;
- all RAM bytes to 0.

REQ-017 ReqReady SHALL read 1 from the first edge after reset rises.

Structure
REQ-018 Package data_mem_pkg SHALL hold:
- the size enum (SZ_BYTE, SZ_HALF, SZ_WORD);
- the state enum (IDLE, WAIT, RESP);
- the MMIO stride constant (4).

REQ-019 Sub-module mem_lane_align SHALL hold the combinational store byte-enable/shift and load extract/extend logic; all state stays in data_mem_mmio.

Verification
REQ-020 Reset, then SW 55 to addr 8, then LW from addr 8:
- RspData=55, RspError=0;
- RspValid exactly LATENCY cycles after accept.

REQ-021 InpWord[0]=87, LW from 64 -> RspData=87; SW to 64 -> RspError=1, store ignored.

REQ-022 With N_IN=2:
- SW 90 to 72 and SW 91 to 76 -> OutWord[0]=90 and OutWord[1]=91, each the cycle after its accept;
- LW from 76 -> 91.

REQ-023 Sub-word lanes and extension:
- SB 0x80 to addr 3 over word 0x11223344 at 0 -> word reads 0x80223344.
- LB from 3 -> 0xFFFFFF80.
- LBU from 3 -> 0x00000080.
- LH from 2 -> 0xFFFF8022.

REQ-024 Faults and mid-transaction reset:
- LH from 1 -> RspError=1, RspData=0.
- LW from 0x3FC -> RspError=1, RspData=0.
- LATENCY=3, reset asserted in WAIT -> no RspValid; OutWord=0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// Shared types and constants for the data memory / MMIO block.
package data_mem_pkg;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'd0,
    SZ_HALF = 2'd1,
    SZ_WORD = 2'd2
  } size_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_e;

  localparam int MMIO_STRIDE = 4;

endpackage

// File: rtl/mem_lane_align.sv
// Combinational byte-lane steering: store byte enables/replication and
// load extraction with sign or zero extension. Holds no state.
module mem_lane_align
  import data_mem_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [1:0]        size,
  input  logic [1:0]        lane,
  input  logic              zext,
  input  logic [31:0]       st_data,
  input  logic [31:0]       ld_word,
  output logic [3:0]        st_be,
  output logic [31:0]       st_word,
  output logic [DATA_W-1:0] ld_data,
  output logic              align_err
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Lane steering, byte enables and load extension for one access
  always_comb begin
    st_be     = 4'b0000;
    st_word   = 32'd0;
    ld_data   = {DATA_W{1'b0}};
    align_err = 1'b0;
    byte_s    = ld_word[{lane, 3'b000} +: 8];
    half_s    = ld_word[{lane[1], 4'b0000} +: 16];
    case (size)
      SZ_BYTE: begin
        st_be   = 4'b0001 << lane;
        st_word = {4{st_data[7:0]}};
        if (zext) begin
          ld_data = DATA_W'(byte_s);
        end else begin
          ld_data = {{(DATA_W-8){byte_s[7]}}, byte_s};
        end
      end
      SZ_HALF: begin
        st_be     = lane[1] ? 4'b1100 : 4'b0011;
        st_word   = {2{st_data[15:0]}};
        align_err = lane[0];
        if (zext) begin
          ld_data = DATA_W'(half_s);
        end else begin
          ld_data = {{(DATA_W-16){half_s[15]}}, half_s};
        end
      end
      SZ_WORD: begin
        st_be     = 4'b1111;
        st_word   = st_data;
        ld_data   = DATA_W'(ld_word);
        align_err = (lane != 2'b00);
      end
      default: begin
        align_err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_mmio.sv
// Byte-addressed data RAM with a small MMIO window of read-only input words
// and registered output words, behind a single-outstanding request/response port.
module data_mem_mmio
  import data_mem_pkg::*;
#(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 10,
  parameter int IO_BASE = 64,
  parameter int N_IN    = 2,
  parameter int N_OUT   = 2,
  parameter int LATENCY = 1
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    ReqValid,
  output logic                    ReqReady,
  input  logic                    ReqWrite,
  input  logic [1:0]              ReqSize,
  input  logic                    ReqUnsigned,
  input  logic [ADDR_W-1:0]       ReqAddr,
  input  logic [DATA_W-1:0]       ReqData,
  output logic                    RspValid,
  output logic [DATA_W-1:0]       RspData,
  output logic                    RspError,
  input  logic [N_IN*DATA_W-1:0]  InpWord,
  output logic [N_OUT*DATA_W-1:0] OutWord
);

  localparam int              RAM_WORDS = IO_BASE / MMIO_STRIDE;
  localparam int              WA_W      = ADDR_W - 2;
  localparam logic [WA_W-1:0] IO_WORD   = WA_W'(RAM_WORDS);
  localparam logic [WA_W-1:0] N_IN_W    = WA_W'(N_IN);
  localparam logic [WA_W-1:0] N_MMIO_W  = WA_W'(N_IN + N_OUT);
  localparam logic [1:0]      WAIT_LAST = 2'((LATENCY > 1) ? (LATENCY - 2) : 0);

  state_e            state_r, state_nx_s;
  logic [1:0]        cnt_r, cnt_nx_s;
  logic              ready_r, rsp_valid_r, rsp_err_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic [31:0]       ram_r [RAM_WORDS];
  logic [31:0]       out_r [N_OUT];

  logic [WA_W-1:0]   word_addr_s, mmio_off_s;
  logic              ram_hit_s, inp_hit_s, out_hit_s;
  logic              align_err_s, req_err_s, accept_s, store_ok_s;
  logic [31:0]       rd_word_s, st_word_s, be_mask_s, merged_s;
  logic [3:0]        st_be_s;
  logic [DATA_W-1:0] ld_data_s;

  assign word_addr_s = ReqAddr[ADDR_W-1:2];
  assign mmio_off_s  = word_addr_s - IO_WORD;
  assign ram_hit_s   = (word_addr_s < IO_WORD);
  assign inp_hit_s   = !ram_hit_s && (mmio_off_s < N_IN_W);
  assign out_hit_s   = !ram_hit_s && !inp_hit_s && (mmio_off_s < N_MMIO_W);

  // Select the addressed storage word; also the merge base for partial stores
  always_comb begin
    rd_word_s = 32'd0;
    for (int i = 0; i < RAM_WORDS; i++) begin
      rd_word_s = (ram_hit_s && (word_addr_s == WA_W'(i))) ? ram_r[i] : rd_word_s;
    end
    for (int i = 0; i < N_IN; i++) begin
      rd_word_s = (inp_hit_s && (mmio_off_s == WA_W'(i))) ? InpWord[i*DATA_W +: 32] : rd_word_s;
    end
    for (int j = 0; j < N_OUT; j++) begin
      rd_word_s = (out_hit_s && (mmio_off_s == WA_W'(N_IN + j))) ? out_r[j] : rd_word_s;
    end
  end

  mem_lane_align #(.DATA_W(DATA_W)) u_align (
    .size      (ReqSize),
    .lane      (ReqAddr[1:0]),
    .zext      (ReqUnsigned),
    .st_data   (ReqData[31:0]),
    .ld_word   (rd_word_s),
    .st_be     (st_be_s),
    .st_word   (st_word_s),
    .ld_data   (ld_data_s),
    .align_err (align_err_s)
  );

  assign be_mask_s  = {{8{st_be_s[3]}}, {8{st_be_s[2]}}, {8{st_be_s[1]}}, {8{st_be_s[0]}}};
  assign merged_s   = (rd_word_s & ~be_mask_s) | (st_word_s & be_mask_s);
  assign req_err_s  = align_err_s || !(ram_hit_s || inp_hit_s || out_hit_s) || (ReqWrite && inp_hit_s);
  assign accept_s   = ReqValid && ready_r;
  assign store_ok_s = accept_s && ReqWrite && !req_err_s;

  // Next-state and wait-counter logic
  always_comb begin
    state_nx_s = state_r;
    cnt_nx_s   = cnt_r;
    case (state_r)
      IDLE: begin
        cnt_nx_s = 2'd0;
        if (!accept_s) begin
          state_nx_s = IDLE;
        end else if (LATENCY == 1) begin
          state_nx_s = RESP;
        end else begin
          state_nx_s = WAIT;
        end
      end
      WAIT: begin
        if (cnt_r == WAIT_LAST) begin
          state_nx_s = RESP;
        end else begin
          cnt_nx_s = cnt_r + 2'd1;
        end
      end
      RESP:    state_nx_s = IDLE;
      default: state_nx_s = IDLE;
    endcase
  end

  // FSM state, counter and handshake strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_r     <= IDLE;
      cnt_r       <= 2'd0;
      ready_r     <= 1'b0;
      rsp_valid_r <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      cnt_r       <= cnt_nx_s;
      ready_r     <= (state_nx_s == IDLE);
      rsp_valid_r <= (state_nx_s == RESP);
    end
  end

  // Response payload is captured at accept and held until the next accept
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rsp_data_r <= {DATA_W{1'b0}};
      rsp_err_r  <= 1'b0;
    end else if (accept_s) begin
      rsp_err_r  <= req_err_s;
      rsp_data_r <= (req_err_s || ReqWrite) ? {DATA_W{1'b0}} : ld_data_s;
    end
  end

  // RAM and output-word storage, written on the accept edge of a clean store
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < RAM_WORDS; i++) ram_r[i] <= 32'd0;
      for (int j = 0; j < N_OUT; j++) out_r[j] <= 32'd0;
    end else if (store_ok_s) begin
      for (int i = 0; i < RAM_WORDS; i++) begin
        if (ram_hit_s && (word_addr_s == WA_W'(i))) ram_r[i] <= merged_s;
      end
      for (int j = 0; j < N_OUT; j++) begin
        if (out_hit_s && (mmio_off_s == WA_W'(N_IN + j))) out_r[j] <= merged_s;
      end
    end
  end

  assign ReqReady = ready_r;
  assign RspValid = rsp_valid_r;
  assign RspData  = rsp_data_r;
  assign RspError = rsp_err_r;

  for (genvar j = 0; j < N_OUT; j++) begin : g_out
    assign OutWord[j*DATA_W +: DATA_W] = DATA_W'(out_r[j]);
  end

endmodule
